// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 frame streamer: FSM encoding, RGB565 palette, width helpers.
// Pure declarations, no logic and no latency.
// No handshake of its own.
package ili9341_pkg;

   // Frame streamer FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_LOAD   = 3'd2,
      ST_STREAM = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // RGB565 solid colours, indexed by mode - NUM_IMAGES
   localparam logic [15:0] RGB_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB_RED     = 16'hF800;
   localparam logic [15:0] RGB_PURPLE  = 16'h780F;
   localparam logic [15:0] RGB_BLACK   = 16'h0000;
   // Fallback for any mode beyond the palette
   localparam logic [15:0] RGB_BLUE    = 16'h001F;

   localparam int NUM_SOLID = 4;

   // Counter/address width for a range of n values; never below 1 bit
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Default widths for the stock 80x80, 4-slot configuration
   localparam int DEF_ADDR_W = clog2_min1(4 * 80 * 80);
   localparam int DEF_SLOT_W = clog2_min1(4);

   // Palette lookup: k is the solid-colour index, anything outside 0..3 gets the fallback
   function automatic logic [15:0] solid_colour(input int k);
      case (k)
         0:       return RGB_CYAN;
         1:       return RGB_RED;
         2:       return RGB_PURPLE;
         3:       return RGB_BLACK;
         default: return RGB_BLUE;
      endcase
   endfunction

endpackage

// File: rtl/ili9341_scale_addr_gen.sv
// Raster counters (sx, src_col, sy, src_row) for an integer-upscaled frame plus ROM address.
// Address and flags are combinational from the counters; counters step one cycle after advance.
// Advances only when told to; holds indefinitely otherwise.
module ili9341_scale_addr_gen
   import ili9341_pkg::*;
#(
   parameter int SRC_W      = 80,
   parameter int SRC_H      = 80,
   parameter int SCALE      = 4,
   parameter int NUM_IMAGES = 4,
   parameter int ADDR_W     = clog2_min1(NUM_IMAGES * SRC_W * SRC_H),
   parameter int SLOT_W     = clog2_min1(NUM_IMAGES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   input  logic              clear,
   input  logic [SLOT_W-1:0] slot,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              last_beat,
   output logic              col_wrap
);

   localparam int SX_W  = clog2_min1(SCALE);
   localparam int COL_W = clog2_min1(SRC_W);
   localparam int ROW_W = clog2_min1(SRC_H);

   localparam logic [SX_W-1:0]   SX_MAX  = SX_W'(SCALE - 1);
   localparam logic [COL_W-1:0]  COL_MAX = COL_W'(SRC_W - 1);
   localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(SRC_H - 1);
   localparam logic [ADDR_W-1:0] IMG_WORDS = ADDR_W'(SRC_W * SRC_H);
   localparam logic [ADDR_W-1:0] ROW_WORDS = ADDR_W'(SRC_W);

   logic [SX_W-1:0]  sx;
   logic [SX_W-1:0]  sy;
   logic [COL_W-1:0] src_col;
   logic [ROW_W-1:0] src_row;
   logic             sx_max;
   logic             sy_max;
   logic             col_max;
   logic             row_max;

   assign sx_max  = (sx == SX_MAX);
   assign sy_max  = (sy == SX_MAX);
   assign col_max = (src_col == COL_MAX);
   assign row_max = (src_row == ROW_MAX);

   assign col_wrap  = sx_max;
   assign last_beat = sx_max && col_max && sy_max && row_max;

   // Slot base is a constant multiply; all terms carried at full address width
   assign rom_addr = ADDR_W'(slot) * IMG_WORDS
                   + ADDR_W'(src_row) * ROW_WORDS
                   + ADDR_W'(src_col);

   // Nested counters: sx -> src_col -> sy -> src_row; sy rewinds src_col to replay the row
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sx      <= '0;
         sy      <= '0;
         src_col <= '0;
         src_row <= '0;
      end else if (clear) begin
         sx      <= '0;
         sy      <= '0;
         src_col <= '0;
         src_row <= '0;
      end else if (advance) begin
         if (sx_max) begin
            sx <= '0;
            if (col_max) begin
               src_col <= '0;
               if (sy_max) begin
                  sy      <= '0;
                  src_row <= row_max ? '0 : src_row + ROW_W'(1);
               end else begin
                  sy <= sy + SX_W'(1);
               end
            end else begin
               src_col <= src_col + COL_W'(1);
            end
         end else begin
            sx <= sx + SX_W'(1);
         end
      end
   end

endmodule

// File: rtl/ili9341_frame_streamer.sv
// Streams one full upscaled ROM image or solid palette frame per launch to the ILI9341 controller.
// Image pixels appear 2 cycles after address (ADDR, LOAD); solid frames are valid the cycle after launch.
// pix_valid/pix_data hold until pix_ready; a stall freezes the frame, mode changes queue to frame end.
module ili9341_frame_streamer
   import ili9341_pkg::*;
#(
   parameter int SRC_W      = 80,
   parameter int SRC_H      = 80,
   parameter int SCALE      = 4,
   parameter int PIXEL_W    = 16,
   parameter int NUM_IMAGES = 4,
   parameter int MODE_W     = 3,
   parameter int CONTINUOUS = 0,
   localparam int ADDR_W    = clog2_min1(NUM_IMAGES * SRC_W * SRC_H)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [MODE_W-1:0]  mode,
   input  logic               start,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [PIXEL_W-1:0] rom_data,
   output logic [PIXEL_W-1:0] pix_data,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic               busy,
   output logic               frame_done
);

   localparam int SLOT_W = clog2_min1(NUM_IMAGES);

   state_t              state;
   state_t              state_nxt;
   logic [MODE_W-1:0]   mode_q;
   logic                pending;
   logic [ADDR_W-1:0]   gen_addr;
   logic [ADDR_W-1:0]   rom_addr_hold;
   logic [PIXEL_W-1:0]  new_colour;
   logic                launch;
   logic                advance;
   logic                last_beat;
   logic                col_wrap;
   logic                accept;
   logic                mode_diff;
   logic                new_is_image;
   logic                cur_is_image;

   assign accept       = pix_valid && pix_ready;
   assign mode_diff    = (mode != mode_q);
   assign new_is_image = (int'(mode) < NUM_IMAGES);
   assign cur_is_image = (int'(mode_q) < NUM_IMAGES);
   assign new_colour   = PIXEL_W'(solid_colour(int'(mode) - NUM_IMAGES));

   assign busy       = (state != ST_IDLE);
   assign frame_done = (state == ST_DONE);

   // The ROM samples the address at the end of ADDR; outside ADDR the last address is held
   assign rom_addr = (state == ST_ADDR) ? gen_addr : rom_addr_hold;

   ili9341_scale_addr_gen #(
      .SRC_W      (SRC_W),
      .SRC_H      (SRC_H),
      .SCALE      (SCALE),
      .NUM_IMAGES (NUM_IMAGES),
      .ADDR_W     (ADDR_W),
      .SLOT_W     (SLOT_W)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .clear     (launch),
      .slot      (SLOT_W'(mode_q)),
      .rom_addr  (gen_addr),
      .last_beat (last_beat),
      .col_wrap  (col_wrap)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, launch and counter advance; a launch overrides the per-state next state
   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      advance   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start || mode_diff || (CONTINUOUS != 0)) begin
               launch = 1'b1;
            end
         end
         ST_ADDR: begin
            state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            if (accept) begin
               advance = 1'b1;
               if (last_beat) begin
                  state_nxt = ST_DONE;
               end else if (col_wrap && cur_is_image) begin
                  state_nxt = ST_ADDR;
               end
            end
         end
         ST_DONE: begin
            if (pending || (CONTINUOUS != 0)) begin
               launch = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      if (launch) begin
         state_nxt = new_is_image ? ST_ADDR : ST_STREAM;
      end
   end

   // Mode latch at launch; a change seen while busy is remembered until the next launch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q  <= '0;
         pending <= 1'b0;
      end else if (launch) begin
         mode_q  <= mode;
         pending <= 1'b0;
      end else if (busy && mode_diff) begin
         pending <= 1'b1;
      end
   end

   // Address hold register so rom_addr stays put outside ADDR (solid frames never move it)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_addr_hold <= '0;
      end else if (state == ST_ADDR) begin
         rom_addr_hold <= gen_addr;
      end
   end

   // Pixel output register: loaded from palette at solid launch or from ROM in LOAD,
   // dropped after the last replica of a source pixel (image) or the last beat of the frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_data  <= '0;
         pix_valid <= 1'b0;
      end else if (launch && !new_is_image) begin
         pix_data  <= new_colour;
         pix_valid <= 1'b1;
      end else if (state == ST_LOAD) begin
         pix_data  <= rom_data;
         pix_valid <= 1'b1;
      end else if (advance && (last_beat || (col_wrap && cur_is_image))) begin
         pix_valid <= 1'b0;
      end
   end

endmodule
